dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the processor's load/store port: the far end of the core's rd_en / wr_en / rd_mask interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns one response pulse.
- Applies byte/half/word store masking and load sign/zero extension.

Parameters:
- DEPTH, 1024, number of 32-bit words of storage (power of 2).
- LATENCY, 1, wait-state cycles between acceptance and response (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_rd_en  input  1  load request.
- req_wr_en  input  1  store request.
- req_mask  input  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended to 32 bits.
- rsp_err  output  1  misaligned-access flag, valid with rsp_valid.

Behaviour:
- Reset value of outputs: req_ready=0 while reset is low; req_ready=1 in the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Storage: memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, wdata, rd_en, wr_en, mask. Go to WAIT with counter=LATENCY, or go directly to RESP if LATENCY=0.
- WAIT: req_ready=0. Counter decrements each cycle; at 1, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- Latency: rsp_valid asserts LATENCY+1 cycles after the acceptance edge. Back-to-back throughput is one request per LATENCY+2 cycles.
- Word index: addr[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around).
- Store commit: the store is written on the WAIT->RESP transition, or on IDLE->RESP when LATENCY=0. A read that follows in a later request therefore sees the new data.
- Store masking:
  - B writes byte addr[1:0] with wdata[7:0].
  - H writes half addr[1] with wdata[15:0].
  - W writes the whole word.
  - Codes 100/101 on a store behave as 000/001.
  - Code 011, 110 or 111: no write; rsp_rdata=0.
- Load extraction: B/BU select byte addr[1:0]; H/HU select half addr[1]; W returns the whole word. B and H sign-extend; BU and HU zero-extend.
- Both req_rd_en and req_wr_en set: treated as a store (wr_en has priority).
- rsp_rdata on a store: 0.
- Neither enable set: request still accepted and responded, rsp_rdata=0, memory unchanged.
- rsp_rdata and rsp_err are held at 0 whenever rsp_valid=0.
- Reset asserted mid-operation: FSM returns to IDLE immediately. A pending store is discarded (not committed), and no response is issued after release.
- req_valid may drop without acceptance; there is no requirement to hold.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, responds with rsp_err=1 and rsp_rdata=0.
  - A misaligned store is suppressed.
  - Response timing is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - Halfword selection uses addr[1] only, and word accesses ignore addr[1:0], so misaligned accesses silently align down.

Test Plan:
- Word round trip (LATENCY=1): SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Sub-word loads after the word above:
  - LB @0x13 -> 0xFFFFFFDE
  - LBU @0x13 -> 0x000000DE
  - LH @0x10 -> 0xFFFFBEEF
  - LHU @0x12 -> 0x0000DEAD
- Byte store: SB wdata=0x123456AA @0x11, then LW @0x10 -> 0xDEADAAEF; other bytes unchanged.
- Timing, LATENCY=2: accept at edge N -> req_ready low at N+1..N+3, rsp_valid high only in cycle N+3, req_ready high again at N+4.
- Reset mid-operation: SW 0x00000000 @0x10 accepted, then reset pulsed low during WAIT. Result: no rsp_valid, and a later LW @0x10 returns the prior 0xDEADAAEF. Also: DEPTH=1024 with LW @0x1010 returns the same word as @0x10 (address wrap).
- Misaligned access, LH @0x11:
  - DMEM_MISALIGN_EN defined -> rsp_err=1, rsp_rdata=0; a misaligned SW @0x12 leaves memory unchanged.
  - Undefined -> rsp_err=0, returns the half at @0x10 (0xFFFFAAEF).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, sized loads/stores.
// Optional macro DMEM_MISALIGN_EN flags and suppresses misaligned halfword/word accesses.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  input  logic [2:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [2:0]  mask_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_rd;
  logic        op_wr;
  logic [2:0]  op_mask;
  logic        accept;
  logic        to_resp;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        mask_ok;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        mem_we;
  logic [AW-1:0] idx;
  logic [31:0] word_rd;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_data;
  logic        unused_addr;

  // With zero latency the commit happens on the accepting edge, so the live inputs are the operands.
  always_comb begin
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_rd    = rd_q;
    op_wr    = wr_q;
    op_mask  = mask_q;
    if (state == IDLE) begin
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_rd    = req_rd_en;
      op_wr    = req_wr_en;
      op_mask  = req_mask;
    end
  end

  assign accept  = req_valid && req_ready;
  assign to_resp = ((state == IDLE) && accept && (LATENCY == 0)) ||
                   ((state == WAIT) && (count == 4'd1));

  assign is_byte = (op_mask[1:0] == 2'b00);
  assign is_half = (op_mask[1:0] == 2'b01);
  assign is_word = (op_mask == 3'b010);
  assign mask_ok = is_byte || is_half || is_word;

`ifdef DMEM_MISALIGN_EN
  assign misalign = (op_rd || op_wr) &&
                    ((is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign idx         = op_addr[AW+1:2];
  assign word_rd     = mem[idx];
  assign unused_addr = ^op_addr[31:AW+2];

  always_comb begin
    be = 4'b0000;
    wd = op_wdata;
    if (is_byte) begin
      be = 4'b0001 << op_addr[1:0];
      wd = {4{op_wdata[7:0]}};
    end else if (is_half) begin
      be = op_addr[1] ? 4'b1100 : 4'b0011;
      wd = {2{op_wdata[15:0]}};
    end else if (is_word) begin
      be = 4'b1111;
    end
  end

  assign mem_we = to_resp && op_wr && mask_ok && !misalign;

  // Loads only; a store (wr_en wins over rd_en) or an invalid code returns zero.
  always_comb begin
    byte_sh   = word_rd >> {op_addr[1:0], 3'b000};
    half_sh   = word_rd >> {op_addr[1], 4'b0000};
    load_data = 32'h0;
    if (op_rd && !op_wr && !misalign) begin
      if (is_byte)
        load_data = {{24{!op_mask[2] && byte_sh[7]}}, byte_sh[7:0]};
      else if (is_half)
        load_data = {{16{!op_mask[2] && half_sh[15]}}, half_sh[15:0]};
      else if (is_word)
        load_data = word_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      mask_q    <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rd_q      <= req_rd_en;
            wr_q      <= req_wr_en;
            mask_q    <= req_mask;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data;
              rsp_err   <= misalign;
            end else begin
              state <= WAIT;
              count <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          if (count == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= misalign;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=2.
module tb_dmem_responder;

  localparam int LAT1 = 1;
  localparam int LAT2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid1, valid2;
  logic [31:0] reqAddr, reqWdata;
  logic        reqRdEn, reqWrEn;
  logic [2:0]  reqMask;
  logic        ready1, ready2, rspValid1, rspValid2, rspErr1, rspErr2;
  logic [31:0] rspRdata1, rspRdata2;

  int assertions = 0;
  int failures   = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_rd_en(reqRdEn), .req_wr_en(reqWrEn),
    .req_mask(reqMask), .rsp_valid(rspValid1), .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_rd_en(reqRdEn), .req_wr_en(reqWrEn),
    .req_mask(reqMask), .rsp_valid(rspValid2), .rsp_rdata(rspRdata2), .rsp_err(rspErr2)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic rd, input logic wr, input logic [2:0] mask,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.mask = mask;
    v.addr = addr; v.wdata = wdata; v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction; returns at the falling edge where the response is seen (or the bound expires).
  task automatic applyStimulus(input int which, input logic rd, input logic wr, input logic [2:0] mask,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output logic readyLeak);
    int n;
    @(negedge clk);
    reqRdEn = rd; reqWrEn = wr; reqMask = mask; reqAddr = addr; reqWdata = wdata;
    if (which == 1) valid1 = 1'b1; else valid2 = 1'b1;
    n = 0;
    while (!((which == 1) ? ready1 : ready2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0; valid2 = 1'b0;
    lat = 1;
    readyLeak = 1'b0;
    while (!((which == 1) ? rspValid1 : rspValid2) && lat < 40) begin
      if ((which == 1) ? ready1 : ready2) readyLeak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if ((which == 1) ? ready1 : ready2) readyLeak = 1'b1;
    rdata = (which == 1) ? rspRdata1 : rspRdata2;
    err   = (which == 1) ? rspErr1 : rspErr2;
  endtask

  task automatic runVectors(input int which, input int latency);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        leak;
    foreach (vecs[i]) begin
      applyStimulus(which, vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].wdata,
                    rdata, err, lat, leak);
      checkOutput({vecs[i].name, " data"}, rdata, vecs[i].expData);
      checkOutput({vecs[i].name, " err"}, {31'b0, err}, {31'b0, vecs[i].expErr});
      checkOutput({vecs[i].name, " latency"}, lat, latency + 1);
      checkOutput({vecs[i].name, " ready low"}, {31'b0, leak}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        leak;
    logic        sawValid;

    reset = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0; reqRdEn = 1'b0; reqWrEn = 1'b0; reqMask = 3'b000;

    repeat (2) @(negedge clk);
    checkOutput("reset ready", {31'b0, ready1}, 32'h0);
    checkOutput("reset ready lat2", {31'b0, ready2}, 32'h0);
    checkOutput("reset rsp_valid", {31'b0, rspValid1}, 32'h0);
    checkOutput("reset rsp_rdata", rspRdata1, 32'h0);
    checkOutput("reset rsp_err", {31'b0, rspErr1}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready after release", {31'b0, ready1}, 32'h1);

    addVec("sw 0x10",        0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    addVec("lw 0x10",        1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    addVec("lb 0x13",        1, 0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0);
    addVec("lbu 0x13",       1, 0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0);
    addVec("lh 0x10",        1, 0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 0);
    addVec("lhu 0x12",       1, 0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 0);
    addVec("sb 0x11",        0, 1, 3'b000, 32'h11,   32'h123456AA, 32'h0,        0);
    addVec("lw after sb",    1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADAAEF, 0);
    addVec("lw wrap 0x1010", 1, 0, 3'b010, 32'h1010, 32'h0,        32'hDEADAAEF, 0);
    addVec("sw 0x20",        0, 1, 3'b010, 32'h20,   32'h11223344, 32'h0,        0);
    addVec("sh 0x22",        0, 1, 3'b001, 32'h22,   32'hABCD5678, 32'h0,        0);
    addVec("lw after sh",    1, 0, 3'b010, 32'h20,   32'h0,        32'h56783344, 0);
    addVec("lb 0x21 pos",    1, 0, 3'b000, 32'h21,   32'h0,        32'h00000033, 0);
    addVec("lh 0x22 pos",    1, 0, 3'b001, 32'h22,   32'h0,        32'h00005678, 0);
    addVec("load code 011",  1, 0, 3'b011, 32'h10,   32'h0,        32'h0,        0);
    addVec("store code 111", 0, 1, 3'b111, 32'h10,   32'h0,        32'h0,        0);
    addVec("lw after 111",   1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADAAEF, 0);
    addVec("no enable",      0, 0, 3'b010, 32'h10,   32'h0,        32'h0,        0);
    addVec("lw after none",  1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADAAEF, 0);
    addVec("rd+wr sb 0x20",  1, 1, 3'b000, 32'h20,   32'h00000077, 32'h0,        0);
    addVec("store code 100", 0, 1, 3'b100, 32'h23,   32'h00000099, 32'h0,        0);
    addVec("store code 101", 0, 1, 3'b101, 32'h20,   32'h1111BEEF, 32'h0,        0);
    addVec("lw 0x20 final",  1, 0, 3'b010, 32'h20,   32'h0,        32'h9978BEEF, 0);
    addVec("lb 0x23 neg",    1, 0, 3'b000, 32'h23,   32'h0,        32'hFFFFFF99, 0);
    runVectors(1, LAT1);

    // LATENCY=2 instance: response in the third cycle after acceptance, ready back right after.
    applyStimulus(2, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, rdata, err, lat, leak);
    checkOutput("lat2 sw latency", lat, LAT2 + 1);
    checkOutput("lat2 sw ready low", {31'b0, leak}, 32'h0);
    applyStimulus(2, 1, 0, 3'b010, 32'h40, 32'h0, rdata, err, lat, leak);
    checkOutput("lat2 lw data", rdata, 32'hCAFEF00D);
    checkOutput("lat2 lw latency", lat, LAT2 + 1);
    checkOutput("lat2 lw ready low", {31'b0, leak}, 32'h0);
    @(negedge clk);
    checkOutput("lat2 pulse width", {31'b0, rspValid2}, 32'h0);
    checkOutput("lat2 rdata idle", rspRdata2, 32'h0);
    checkOutput("lat2 ready again", {31'b0, ready2}, 32'h1);

    // Reset during WAIT must drop the pending store and suppress its response.
    @(negedge clk);
    reqRdEn = 1'b0; reqWrEn = 1'b1; reqMask = 3'b010; reqAddr = 32'h10; reqWdata = 32'h0;
    valid1 = 1'b1;
    for (int n = 0; n < 20 && !ready1; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("mid reset ready", {31'b0, ready1}, 32'h0);
    checkOutput("mid reset rsp_valid", {31'b0, rspValid1}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sawValid = 1'b0;
    @(negedge clk);
    checkOutput("ready after mid reset", {31'b0, ready1}, 32'h1);
    for (int n = 0; n < 4; n++) begin
      if (rspValid1) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("no rsp after reset", {31'b0, sawValid}, 32'h0);
    applyStimulus(1, 1, 0, 3'b010, 32'h10, 32'h0, rdata, err, lat, leak);
    checkOutput("lw after reset", rdata, 32'hDEADAAEF);

    vecs.delete();
`ifdef DMEM_MISALIGN_EN
    addVec("lh 0x11 mis",    1, 0, 3'b001, 32'h11, 32'h0, 32'h0,        1);
    addVec("lhu 0x13 mis",   1, 0, 3'b101, 32'h13, 32'h0, 32'h0,        1);
    addVec("sw 0x12 mis",    0, 1, 3'b010, 32'h12, 32'h0, 32'h0,        1);
    addVec("lw after mis",   1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0);
`else
    addVec("lh 0x11 align",  1, 0, 3'b001, 32'h11, 32'h0, 32'hFFFFAAEF, 0);
    addVec("lhu 0x13 align", 1, 0, 3'b101, 32'h13, 32'h0, 32'h0000DEAD, 0);
    addVec("sw 0x12 align",  0, 1, 3'b010, 32'h12, 32'h0, 32'h0,        0);
    addVec("lw after align", 1, 0, 3'b010, 32'h10, 32'h0, 32'h0,        0);
`endif
    runVectors(1, LAT1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
